// File: rtl/writeback_regfile.sv
// Writeback stage and architectural register file. Two writeback channels (execute and memory)
// feed one register array. Reads bypass same-cycle writes, and a load scoreboard drives the stall output.
module writeback_regfile #(
    parameter int          XLEN          = 32,
    parameter int          NREGS         = 32,
    parameter int          NRD           = 2,
    parameter logic [31:0] SP_RESET      = 32'hC000_0000,
    parameter logic [1:0]  WB_SRC_ALU    = 2'd0,
    parameter logic [1:0]  WB_SRC_PCNEXT = 2'd1,
    localparam int         AW            = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we0,
    input  logic [AW-1:0]       rd0,
    input  logic [1:0]          sig_src0,
    input  logic [XLEN-1:0]     res_alu,
    input  logic [XLEN-1:0]     res_pc,
    input  logic                we1,
    input  logic [AW-1:0]       rd1,
    input  logic [XLEN-1:0]     res_mem,
    input  logic                issue_ld,
    input  logic [AW-1:0]       issue_rd,
    input  logic [NRD*AW-1:0]   rs,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NREGS-1:0]    busy,
    output logic                stall,
    input  logic                en_trace
);

    localparam logic [XLEN-1:0] SP_INIT = XLEN'(SP_RESET);

    logic [XLEN-1:0]  regs [NREGS];
    logic [XLEN-1:0]  res0;
    logic             src_ok;
    logic             wr0;
    logic             wr1;
    logic [NREGS-1:0] busy_next;
    logic [NRD-1:0]   port_stall;

    // The write log is produced by the simulation environment, so the enable has no hardware sink.
    logic unused_trace;
    assign unused_trace = en_trace;

    always_comb begin
        res0   = res_alu;
        src_ok = 1'b0;
        if (sig_src0 == WB_SRC_ALU) begin
            res0   = res_alu;
            src_ok = 1'b1;
        end else if (sig_src0 == WB_SRC_PCNEXT) begin
            res0   = res_pc + XLEN'(4);
            src_ok = 1'b1;
        end
    end

    // On a destination collision the execute channel wins and the memory data is dropped.
    assign wr0 = we0 && src_ok && (rd0 != '0);
    assign wr1 = we1 && (rd1 != '0) && !(wr0 && (rd1 == rd0));

    always_comb begin
        busy_next = busy;
        if (we1 && (rd1 != '0))
            busy_next[rd1] = 1'b0;
        if (issue_ld && (issue_rd != '0))
            busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= (i == 2) ? SP_INIT : '0;
            busy <= '0;
        end else begin
            if (wr0)
                regs[rd0] <= res0;
            if (wr1)
                regs[rd1] <= res_mem;
            busy <= busy_next;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;

        assign addr = rs[k*AW +: AW];

        always_comb begin
            if (addr == '0)
                data = '0;
            else if (wr0 && (rd0 == addr))
                data = res0;
            else if (we1 && (rd1 == addr))
                data = res_mem;
            else
                data = regs[addr];
        end

        assign rs_data[k*XLEN +: XLEN] = data;
        assign port_stall[k] = (addr != '0) && busy[addr] && !(we1 && (rd1 == addr));
    end

    assign stall = |port_stall;

endmodule
